// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: priority stall vector, bubble insertion and a
// registered exception flush/redirect sequencer. Optional watchdog: PIPE_STALL_WDOG_EN.
module pipe_stall_ctrl #(
    parameter int STAGES       = 5,
    parameter int AW           = 32,
    parameter int GUARD_CYCLES = 2,
    parameter int WDOG_LIMIT   = 1024,
    parameter int WDOG_W       = 11
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic [STAGES-2:0] stallreq,
    input  logic              excp_req,
    input  logic [AW-1:0]     excp_target,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              redirect_valid,
    output logic [AW-1:0]     redirect_pc,
    output logic              busy,
    output logic              wdog_timeout
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    if ((2 ** WDOG_W) <= WDOG_LIMIT) begin : g_wdog_w_chk
        $error("pipe_stall_ctrl: WDOG_W too narrow for WDOG_LIMIT");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [GW-1:0]     guard_cnt;
    logic              accept;
    logic [STAGES-1:0] req_stall, req_bubble;

    assign accept = excp_req && ((state == IDLE) || ((state == GUARD) && (guard_cnt == '0)));

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = FLUSH;
            FLUSH:   state_n = (GUARD_CYCLES > 0) ? GUARD : IDLE;
            GUARD:   if (guard_cnt == '0) state_n = accept ? FLUSH : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            guard_cnt   <= '0;
            redirect_pc <= '0;
        end else if (accept) begin
            guard_cnt   <= GW'(GUARD_CYCLES);
            redirect_pc <= excp_target;
        end else if ((state == GUARD) && (guard_cnt != '0)) begin
            guard_cnt <= guard_cnt - 1'b1;
        end
    end

    // Ascending scan: the highest requesting stage overwrites lower ones.
    always_comb begin
        req_stall  = '0;
        req_bubble = '0;
        for (int unsigned i = 0; i < STAGES - 1; i++) begin
            if (stallreq[i]) begin
                req_stall  = ~({STAGES{1'b1}} << (i + 2));
                req_bubble = {{(STAGES-1){1'b0}}, 1'b1} << (i + 2);
            end
        end
    end

    always_comb begin
        stall          = '0;
        bubble         = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        busy           = (state != IDLE);
        if (state == FLUSH) begin
            flush          = '1;
            redirect_valid = 1'b1;
        end else if (cpu_rst_n) begin
            stall  = req_stall;
            bubble = req_bubble;
        end
    end

`ifdef PIPE_STALL_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_flag;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else if (accept) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else if (stallreq == '0) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WDOG_W'(WDOG_LIMIT)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1)) wdog_flag <= 1'b1;
        end
    end

    assign wdog_timeout = wdog_flag;
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stall/bubble vector table plus sequencer,
// reset and watchdog sequences (watchdog expectations follow PIPE_STALL_WDOG_EN).
module tb_pipe_stall_ctrl;

    localparam int STAGES = 5;
    localparam int AW     = 32;
`ifdef PIPE_STALL_WDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [STAGES-2:0] stallreq;
    logic              excp_req;
    logic [AW-1:0]     excp_target;
    logic [STAGES-1:0] stall, bubble, flush;
    logic              redirect_valid, busy, wdog_timeout;
    logic [AW-1:0]     redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .STAGES(STAGES), .AW(AW), .GUARD_CYCLES(2), .WDOG_LIMIT(8), .WDOG_W(4)
    ) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .stallreq(stallreq),
        .excp_req(excp_req), .excp_target(excp_target),
        .stall(stall), .bubble(bubble), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .wdog_timeout(wdog_timeout)
    );

    typedef struct {
        logic [3:0] req;
        logic [4:0] exp_stall;
        logic [4:0] exp_bubble;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        excp_req = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        vecs[0] = '{4'b0000, 5'b00000, 5'b00000};
        vecs[1] = '{4'b0001, 5'b00011, 5'b00100};
        vecs[2] = '{4'b0010, 5'b00111, 5'b01000};
        vecs[3] = '{4'b0011, 5'b00111, 5'b01000};
        vecs[4] = '{4'b0100, 5'b01111, 5'b10000};
        vecs[5] = '{4'b0101, 5'b01111, 5'b10000};
        vecs[6] = '{4'b1000, 5'b11111, 5'b00000};
        vecs[7] = '{4'b1010, 5'b11111, 5'b00000};
        vecs[8] = '{4'b1111, 5'b11111, 5'b00000};
        vecs[9] = '{4'b0110, 5'b01111, 5'b10000};

        rst_n       = 1'b0;
        stallreq    = 4'b1000;
        excp_req    = 1'b0;
        excp_target = '0;
        #2;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_bubble", 64'(bubble), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        @(negedge clk);
        rst_n    = 1'b1;
        stallreq = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle_outs%0d", i),
                  {stall, bubble, flush, redirect_valid, busy, wdog_timeout},
                  64'd0);
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stallreq = vecs[i].req;
            #1;
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
            check($sformatf("vec%0d_bubble", i), 64'(bubble), 64'(vecs[i].exp_bubble));
        end

        // Exception while MEM stalls
        @(negedge clk);
        stallreq    = 4'b1000;
        excp_req    = 1'b1;
        excp_target = 32'hBFC0_0380;
        tick();
        check("exc_flush", 64'(flush), 64'h1F);
        check("exc_rv", 64'(redirect_valid), 64'd1);
        check("exc_pc", 64'(redirect_pc), 64'hBFC0_0380);
        check("exc_stall", 64'(stall), 64'd0);
        check("exc_bubble", 64'(bubble), 64'd0);
        @(negedge clk);
        excp_req = 1'b0;
        tick();
        check("guard_flush", 64'(flush), 64'd0);
        check("guard_rv", 64'(redirect_valid), 64'd0);
        check("guard_busy", 64'(busy), 64'd1);
        check("guard_stall", 64'(stall), 64'h1F);
        tick();
        tick();
        check("guard_busy_cnt0", 64'(busy), 64'd1);
        tick();
        check("idle_again", 64'(busy), 64'd0);
        check("pc_hold", 64'(redirect_pc), 64'hBFC0_0380);

        // Back-to-back pulses: only edges t and t+4 accept
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stallreq    = 4'b0000;
            excp_req    = 1'b1;
            excp_target = 32'hA000_0000 + 32'(k);
            tick();
            check($sformatf("b2b_flush%0d", k), 64'(flush),
                  (k == 0 || k == 4) ? 64'h1F : 64'd0);
            check($sformatf("b2b_pc%0d", k), 64'(redirect_pc),
                  (k == 4) ? 64'hA000_0004 : 64'hA000_0000);
            check($sformatf("b2b_busy%0d", k), 64'(busy), 64'd1);
        end
        drain();
        check("b2b_drained", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of FLUSH
        @(negedge clk);
        stallreq    = 4'b1000;
        excp_req    = 1'b1;
        excp_target = 32'h1234_5678;
        tick();
        check("pre_rst_flush", 64'(flush), 64'h1F);
        rst_n = 1'b0;
        #1;
        check("arst_flush", 64'(flush), 64'd0);
        check("arst_rv", 64'(redirect_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_pc", 64'(redirect_pc), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        excp_req = 1'b0;
        stallreq = 4'b0000;
        rst_n    = 1'b1;

        // Watchdog: 8 stalled cycles reach the limit
        @(negedge clk);
        stallreq = 4'b0100;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("wdog_edge%0d", e), 64'(wdog_timeout),
                  (e == 8) ? 64'(WD_ON) : 64'd0);
        end
        @(negedge clk);
        stallreq = 4'b0000;
        repeat (3) tick();
        check("wdog_sticky", 64'(wdog_timeout), 64'(WD_ON));
        @(negedge clk);
        excp_req    = 1'b1;
        excp_target = 32'h8000_0180;
        tick();
        check("wdog_clr_flush", 64'(flush), 64'h1F);
        check("wdog_cleared", 64'(wdog_timeout), 64'd0);
        drain();
        check("final_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
